// File: rtl/uart_rx_if.sv
// Core-side read/status bundle of the UART receiver (pop handshake plus sticky error flags).
// Latency: wires only; timing is set by the receiver that drives the slave side.
// Backpressure: reader drains with rd_en; the receiver drops bytes into a full buffer and raises overrun.
interface uart_rx_if;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       err_clr;
    logic       frame_err;
    logic       overrun;

    // Core-side arbiter: pops bytes and clears flags.
    modport master (
        output rd_en,
        output err_clr,
        input  rd_data,
        input  rd_valid,
        input  frame_err,
        input  overrun
    );

    // Receiver side.
    modport slave (
        input  rd_en,
        input  err_clr,
        output rd_data,
        output rd_valid,
        output frame_err,
        output overrun
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling, receive buffer (FIFO when UART_RX_FIFO_EN is defined, else one holding register), sticky frame_err/overrun.
// Latency: byte appears on rd_data/rd_valid one cycle after the mid-stop-bit sample; rd_en -> next byte or rd_valid low in one cycle.
// Backpressure: none toward the line; a byte arriving at a full buffer with no same-cycle pop is dropped and sets overrun.
module uart_rx #(
    parameter int CLK_HZ     = 12000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic     clk,
    input  logic     resetn,
    input  logic     rx,
    uart_rx_if.slave bus
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int CW           = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);

    if (CLKS_PER_BIT < 8) begin : g_bad_baud
        $error("uart_rx: CLK_HZ/BAUD must be at least 8");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_rx: FIFO_DEPTH must be a power of two and at least 2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    // ------------------------------------------------------------------
    // Line synchronizer
    // ------------------------------------------------------------------
    logic       rx_meta;
    logic       rxs;
    logic [1:0] sync_fill;
    logic       armed;

    // Two-flop synchronizer; both flops reset high so reset itself never looks like a start bit.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

    // After reset the line must be seen high through a filled synchronizer before a start bit
    // counts, so a frame cut by reset is not picked up halfway through.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync_fill <= 2'b00;
            armed     <= 1'b0;
        end else begin
            sync_fill <= {sync_fill[0], 1'b1};
            if (sync_fill[1] && rxs) begin
                armed <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM and bit timing
    // ------------------------------------------------------------------
    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          cnt_zero;
    logic          load_half;
    logic          load_full;
    logic          clr_idx;
    logic          shift_en;
    logic          byte_done;
    logic          ferr_set;

    assign cnt_zero = (cnt == '0);

    // State register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and per-cycle datapath controls.
    always_comb begin
        state_nxt = state;
        load_half = 1'b0;
        load_full = 1'b0;
        clr_idx   = 1'b0;
        shift_en  = 1'b0;
        byte_done = 1'b0;
        ferr_set  = 1'b0;
        case (state)
            S_IDLE: begin
                if (armed && !rxs) begin
                    load_half = 1'b1;
                    state_nxt = S_START;
                end
            end
            S_START: begin
                if (cnt_zero) begin
                    if (rxs) begin
                        state_nxt = S_IDLE;
                    end else begin
                        load_full = 1'b1;
                        clr_idx   = 1'b1;
                        state_nxt = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (cnt_zero) begin
                    shift_en  = 1'b1;
                    load_full = 1'b1;
                    if (bit_idx == 3'd7) begin
                        state_nxt = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (cnt_zero) begin
                    if (rxs) begin
                        byte_done = 1'b1;
                        state_nxt = S_IDLE;
                    end else begin
                        ferr_set  = 1'b1;
                        state_nxt = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                if (rxs) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Bit-period down-counter, bit index and LSB-first shift register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            if (load_half) begin
                cnt <= HALF_LOAD;
            end else if (load_full) begin
                cnt <= FULL_LOAD;
            end else if (!cnt_zero) begin
                cnt <= cnt - CW'(1);
            end
            if (clr_idx) begin
                bit_idx <= '0;
            end else if (shift_en) begin
                bit_idx <= bit_idx + 3'd1;
            end
            if (shift_en) begin
                shreg <= {rxs, shreg[7:1]};
            end
        end
    end

    // ------------------------------------------------------------------
    // Receive buffer
    // ------------------------------------------------------------------
    logic       pop;
    logic       full;
    logic       accept;
    logic       ovr_set;
    logic [7:0] rd_data_q;

    // A pop only counts while data is present; a pop on the push cycle frees room in a full buffer.
    assign pop     = bus.rd_en && bus.rd_valid;
    assign accept  = byte_done && (!full || pop);
    assign ovr_set = byte_done && full && !pop;
    assign bus.rd_data = rd_data_q;

`ifdef UART_RX_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [7:0] mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [AW:0] wr_ptr_nxt;
    logic [AW:0] rd_ptr_nxt;
    logic [7:0]  head_nxt;

    assign full         = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign bus.rd_valid = (wr_ptr != rd_ptr);
    assign wr_ptr_nxt   = accept ? wr_ptr + (AW+1)'(1) : wr_ptr;
    assign rd_ptr_nxt   = pop ? rd_ptr + (AW+1)'(1) : rd_ptr;
    // When the next head is the slot being written this cycle, forward the incoming byte.
    assign head_nxt     = (rd_ptr_nxt == wr_ptr) ? shreg : mem[rd_ptr_nxt[AW-1:0]];

    // Pointer update and storage write.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
            if (accept) begin
                mem[wr_ptr[AW-1:0]] <= shreg;
            end
        end
    end

    // Registered fall-through head: reload whenever the buffer is non-empty next cycle.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rd_data_q <= 8'h00;
        end else if (wr_ptr_nxt != rd_ptr_nxt) begin
            rd_data_q <= head_nxt;
        end
    end
`else
    logic hold_full;

    assign full         = hold_full;
    assign bus.rd_valid = hold_full;

    // Single holding register; a dropped byte leaves the held byte untouched.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            hold_full <= 1'b0;
            rd_data_q <= 8'h00;
        end else if (accept) begin
            hold_full <= 1'b1;
            rd_data_q <= shreg;
        end else if (pop) begin
            hold_full <= 1'b0;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Sticky error flags
    // ------------------------------------------------------------------
    logic frame_err_q;
    logic overrun_q;

    assign bus.frame_err = frame_err_q;
    assign bus.overrun   = overrun_q;

    // Sticky flags; a set condition wins over a coincident clear.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            if (ferr_set) begin
                frame_err_q <= 1'b1;
            end else if (bus.err_clr) begin
                frame_err_q <= 1'b0;
            end
            if (ovr_set) begin
                overrun_q <= 1'b1;
            end else if (bus.err_clr) begin
                overrun_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: serial frames driven bit by bit, received bytes compared against a byte-queue model.
// Latency: checks the rd_valid/frame_err/overrun edge exactly at the mid-stop-bit boundary.
// Backpressure: exercises full buffer, simultaneous push/pop and err_clr/overrun collisions.
module tb_uart_rx;
    localparam int CPB        = 12000000 / 115200;
    // Ticks from driving the start bit low until the received byte is visible.
    localparam int VALID_TICK = 1 + 2 + CPB / 2 + 9 * CPB;
`ifdef UART_RX_FIFO_EN
    localparam int CAP = 8;
`else
    localparam int CAP = 1;
`endif

    logic clk = 1'b0;
    logic resetn;
    logic rx;
    uart_rx_if bus();

    uart_rx #(.CLK_HZ(12000000), .BAUD(115200), .FIFO_DEPTH(8)) dut (
        .clk   (clk),
        .resetn(resetn),
        .rx    (rx),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: bytes the reader should see, in order, and the expected overrun flag.
    logic [7:0] exp_q[$];
    logic       m_ovr;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic drive_frame(input logic [7:0] b, input logic stop, input int p);
        rx = 1'b0;
        ticks(p);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            ticks(p);
        end
        rx = stop;
        ticks(p);
    endtask

    function automatic void model_push(input logic [7:0] b);
        if (exp_q.size() < CAP) exp_q.push_back(b);
        else m_ovr = 1'b1;
    endfunction

    task automatic pop_one();
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
    endtask

    task automatic clear_errs();
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0; rx = 1'b1; bus.rd_en = 1'b0; bus.err_clr = 1'b0;
        exp_q.delete(); m_ovr = 1'b0;
        ticks(4);
        checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %b want 0", bus.rd_valid); end
        checks++; if (bus.rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data: got %h want 00", bus.rd_data); end
        checks++; if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b want 0", bus.frame_err); end
        checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b want 0", bus.overrun); end
        resetn = 1'b1;
        ticks(8);
    endtask

    task automatic test_single_byte();
        logic v_early, v_on;
        logic [7:0] d_on;
        fork
            drive_frame(8'hA5, 1'b1, CPB);
            begin
                ticks(VALID_TICK - 1);
                v_early = bus.rd_valid;
                tick();
                v_on = bus.rd_valid;
                d_on = bus.rd_data;
            end
        join
        checks++; if (v_early !== 1'b0) begin errors++; $display("FAIL single_valid_early: got %b want 0", v_early); end
        checks++; if (v_on !== 1'b1) begin errors++; $display("FAIL single_valid_on_time: got %b want 1", v_on); end
        checks++; if (d_on !== 8'hA5) begin errors++; $display("FAIL single_data: got %h want a5", d_on); end
        pop_one();
        checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL single_pop_empties: got %b want 0", bus.rd_valid); end
    endtask

    task automatic test_glitch();
        logic [7:0] b;
        rx = 1'b0;
        ticks(20);
        rx = 1'b1;
        ticks(2 * CPB);
        checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL glitch_rd_valid: got %b want 0", bus.rd_valid); end
        checks++; if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL glitch_frame_err: got %b want 0", bus.frame_err); end
        checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL glitch_overrun: got %b want 0", bus.overrun); end
        b = 8'($urandom);
        drive_frame(b, 1'b1, CPB);
        model_push(b);
        checks++; if (bus.rd_data !== exp_q[0]) begin errors++; $display("FAIL glitch_next_byte: got %h want %h", bus.rd_data, exp_q[0]); end
        pop_one();
        exp_q.delete(0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            drive_frame(8'(i), 1'b1, CPB);
            model_push(8'(i));
        end
        checks++; if (bus.rd_valid !== 1'b1) begin errors++; $display("FAIL b2b_rd_valid: got %b want 1", bus.rd_valid); end
        checks++; if (bus.overrun !== m_ovr) begin errors++; $display("FAIL b2b_overrun_8: got %b want %b", bus.overrun, m_ovr); end
        drive_frame(8'hFF, 1'b1, CPB);
        model_push(8'hFF);
        checks++; if (bus.overrun !== 1'b1) begin errors++; $display("FAIL b2b_overrun_9: got %b want 1", bus.overrun); end
        while (exp_q.size() > 0) begin
            checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== exp_q[0]) begin errors++; $display("FAIL b2b_drain: got valid %b data %h want valid 1 data %h", bus.rd_valid, bus.rd_data, exp_q[0]); end
            pop_one();
            exp_q.delete(0);
        end
        checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL b2b_drained: got %b want 0", bus.rd_valid); end
        clear_errs();
        m_ovr = 1'b0;
        checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL b2b_err_clr: got %b want 0", bus.overrun); end
    endtask

    task automatic test_frame_error();
        logic [7:0] b;
        logic f_early, f_on;
        int hi;
        b = 8'($urandom);
        fork
            drive_frame(b, 1'b0, CPB);
            begin
                ticks(VALID_TICK - 1);
                f_early = bus.frame_err;
                tick();
                f_on = bus.frame_err;
            end
        join
        checks++; if (f_early !== 1'b0) begin errors++; $display("FAIL ferr_early: got %b want 0", f_early); end
        checks++; if (f_on !== 1'b1) begin errors++; $display("FAIL ferr_on_time: got %b want 1", f_on); end
        clear_errs();
        checks++; if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL ferr_clear: got %b want 0", bus.frame_err); end
        hi = 0;
        for (int i = 0; i < 30 * CPB; i++) begin
            tick();
            if (bus.frame_err) hi++;
        end
        checks++; if (hi !== 0) begin errors++; $display("FAIL ferr_break_reassert: got %0d high cycles want 0", hi); end
        checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL ferr_no_push: got %b want 0", bus.rd_valid); end
        rx = 1'b1;
        ticks(CPB);
        drive_frame(8'h3C, 1'b1, CPB);
        model_push(8'h3C);
        checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 8'h3C) begin errors++; $display("FAIL ferr_recover: got valid %b data %h want valid 1 data 3c", bus.rd_valid, bus.rd_data); end
        checks++; if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL ferr_stays_clear: got %b want 0", bus.frame_err); end
        pop_one();
        exp_q.delete(0);
    endtask

    task automatic test_full_simultaneous();
        logic [7:0] nb, d1;
        logic o1, o2;
        int n;
        for (int i = 0; i < CAP; i++) begin
            nb = 8'($urandom);
            drive_frame(nb, 1'b1, CPB);
            model_push(nb);
        end
        checks++; if (bus.rd_valid !== 1'b1 || bus.overrun !== 1'b0) begin errors++; $display("FAIL full_fill: got valid %b ovr %b want valid 1 ovr 0", bus.rd_valid, bus.overrun); end
        nb = 8'($urandom);
        fork
            drive_frame(nb, 1'b1, CPB);
            begin
                ticks(VALID_TICK - 1);
                bus.rd_en = 1'b1;
                tick();
                bus.rd_en = 1'b0;
                o1 = bus.overrun;
                d1 = bus.rd_data;
            end
        join
        exp_q.delete(0);
        exp_q.push_back(nb);
        checks++; if (o1 !== 1'b0) begin errors++; $display("FAIL full_pushpop_overrun: got %b want 0", o1); end
        checks++; if (d1 !== exp_q[0]) begin errors++; $display("FAIL full_pushpop_head: got %h want %h", d1, exp_q[0]); end
        nb = 8'($urandom);
        fork
            drive_frame(nb, 1'b1, CPB);
            begin
                ticks(VALID_TICK - 1);
                bus.err_clr = 1'b1;
                tick();
                bus.err_clr = 1'b0;
                o2 = bus.overrun;
            end
        join
        model_push(nb);
        checks++; if (o2 !== 1'b1) begin errors++; $display("FAIL full_set_beats_clr: got %b want 1", o2); end
        n = 0;
        while (exp_q.size() > 0) begin
            checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== exp_q[0]) begin errors++; $display("FAIL full_drain: got valid %b data %h want valid 1 data %h", bus.rd_valid, bus.rd_data, exp_q[0]); end
            pop_one();
            exp_q.delete(0);
            n++;
        end
        checks++; if (bus.rd_valid !== 1'b0 || n !== CAP) begin errors++; $display("FAIL full_occupancy: got valid %b after %0d pops want valid 0 after %0d", bus.rd_valid, n, CAP); end
        clear_errs();
        m_ovr = 1'b0;
        checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL full_err_clr: got %b want 0", bus.overrun); end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] nb;
        logic v;
        nb = 8'($urandom);
        drive_frame(nb, 1'b1, CPB);
        model_push(nb);
        fork
            drive_frame(8'h0F, 1'b1, CPB);
            begin
                ticks(5 * CPB + CPB / 2);
                resetn = 1'b0;
                ticks(4);
                resetn = 1'b1;
                v = bus.rd_valid;
            end
        join
        exp_q.delete();
        m_ovr = 1'b0;
        checks++; if (v !== 1'b0) begin errors++; $display("FAIL rstmid_flush: got %b want 0", v); end
        ticks(10 * CPB);
        checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL rstmid_no_ghost: got %b want 0", bus.rd_valid); end
        drive_frame(8'h5A, 1'b1, CPB);
        model_push(8'h5A);
        checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 8'h5A) begin errors++; $display("FAIL rstmid_byte: got valid %b data %h want valid 1 data 5a", bus.rd_valid, bus.rd_data); end
        checks++; if (bus.frame_err !== 1'b0 || bus.overrun !== 1'b0) begin errors++; $display("FAIL rstmid_flags: got ferr %b ovr %b want 0 0", bus.frame_err, bus.overrun); end
        pop_one();
        exp_q.delete(0);
        checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL rstmid_only_one: got %b want 0", bus.rd_valid); end
    endtask

    task automatic test_random();
        logic [7:0] b;
        int p;
        for (int n = 0; n < 6; n++) begin
            b = 8'($urandom);
            p = int'($urandom_range(100, 108));
            drive_frame(b, 1'b1, p);
            model_push(b);
            ticks(int'($urandom_range(1, 40)));
            if ($urandom_range(0, 1) == 1 && exp_q.size() > 0) begin
                checks++; if (bus.rd_data !== exp_q[0]) begin errors++; $display("FAIL rand_pop: got %h want %h", bus.rd_data, exp_q[0]); end
                pop_one();
                exp_q.delete(0);
            end
        end
        checks++; if (bus.overrun !== m_ovr || bus.frame_err !== 1'b0) begin errors++; $display("FAIL rand_flags: got ovr %b ferr %b want ovr %b ferr 0", bus.overrun, bus.frame_err, m_ovr); end
        while (exp_q.size() > 0) begin
            checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== exp_q[0]) begin errors++; $display("FAIL rand_drain: got valid %b data %h want valid 1 data %h", bus.rd_valid, bus.rd_data, exp_q[0]); end
            pop_one();
            exp_q.delete(0);
        end
        checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL rand_drained: got %b want 0", bus.rd_valid); end
        clear_errs();
        m_ovr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_glitch();
        test_back_to_back();
        test_frame_error();
        test_full_simultaneous();
        test_reset_mid_frame();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
# uart_rx

Memory-mappable UART receiver for the 12 MHz multicore SoC, the receive-side counterpart of the existing `uart` transmitter. It recovers 8N1 frames from the asynchronous `rx` pin using a bit-period counter with mid-bit sampling. Received bytes go into a small receive buffer that the core-side memory/IO arbiter drains through a simple pop handshake. Sticky framing-error and overrun flags are exposed for a status register.

## Interface
- `CLK_HZ`, 12000000, system clock frequency in Hz.
- `BAUD`, 115200, line rate.
  - `CLKS_PER_BIT` = `CLK_HZ/BAUD` (integer division), which is 104 at the defaults. It must be ≥ 8.
- `FIFO_DEPTH`, 8, receive FIFO depth. Must be a power of two, ≥ 2. Used only when `UART_RX_FIFO_EN` is defined.
- `clk`  in  1  system clock.
- `resetn`  in  1  synchronous, active-low reset.
- `rx`  in  1  asynchronous serial input, idles high.
- `rd_en`  in  1  pop strobe. Ignored when `rd_valid`=0.
- `rd_data`  out  8  oldest unread byte. Valid while `rd_valid`=1.
- `rd_valid`  out  1  buffer non-empty.
- `err_clr`  in  1  clears both sticky error flags.
- `frame_err`  out  1  sticky: a stop bit was sampled low.
- `overrun`  out  1  sticky: a good byte was dropped because the buffer was full.

## Operation
- **Input synchronizer:** `rx` passes through a 2-flop synchronizer; both flops reset to 1. All logic below uses the synchronized value `rxs`.
- **FSM states:** IDLE, START, DATA, STOP, BREAK.
  - **IDLE:** when `rxs`=0, load the bit counter with `CLKS_PER_BIT/2 - 1` and go to START.
  - **START:** when the counter expires, sample `rxs`.
    - 1: false start, return to IDLE.
    - 0: reload the counter with `CLKS_PER_BIT-1`, clear the bit index, go to DATA.
  - **DATA:** on each counter expiry, shift `rxs` into the shift register, LSB first, and reload the counter. After bit index 7, go to STOP.
  - **STOP:** on counter expiry, sample `rxs`.
    - 1: push the byte and go to IDLE. This occurs at mid-stop-bit, so back-to-back frames are received.
    - 0: set `frame_err`, discard the byte, go to BREAK.
  - **BREAK:** wait for `rxs`=1, then go to IDLE. This prevents a held-low line from being read as repeated frames.
- **Counters:** the bit counter is `$clog2(CLKS_PER_BIT)` bits wide and counts down; expiry is the cycle the counter equals 0. The bit index is 3 bits.
- **Push:** if the buffer is full and no pop occurs in the same cycle, the byte is dropped and `overrun` is set. Buffer contents are unchanged.
- **Pop:** `rd_en` while `rd_valid`=1 removes the head. `rd_data` is registered first-word-fall-through and updates the cycle after the pop.
- **Push and pop in the same cycle:**
  - Buffer full: both are accepted, occupancy stays the same, no overrun.
  - Buffer empty: the pop is ignored and the push is accepted.
- **Error flags:** set and clear only through the rules above. If `err_clr` and a set condition occur in the same cycle, the set wins.
- **Reset:**
  - `resetn`=0, including mid-frame, forces IDLE and empties the buffer.
  - Reset values: `rd_valid`=0, `rd_data`=8'h00, `frame_err`=0, `overrun`=0.
  - A frame that was in progress is lost. Reception restarts only on a fresh falling edge seen after reset.

## Timing
- Let cycle 0 be the first `clk` edge at which `rx` is sampled low. Then:
  - `rxs` falls at cycle 2.
  - The start-bit sample is at cycle 2 + `CLKS_PER_BIT/2`.
  - Data bit *k* is sampled at cycle 2 + `CLKS_PER_BIT/2` + (k+1)·`CLKS_PER_BIT`.
  - The stop-bit sample is at cycle 2 + `CLKS_PER_BIT/2` + 9·`CLKS_PER_BIT`.
  - `rd_valid` and `rd_data` are valid 1 cycle after the stop-bit sample. At the defaults this is cycle 991.
- `rd_en` → next byte on `rd_data`, or `rd_valid` low: 1 cycle.
- `frame_err` and `overrun` assert 1 cycle after the stop-bit sample that caused them.
- `err_clr` → flags low: 1 cycle.
- Tolerated baud mismatch: ±4 % with the default parameters.

## Configuration
- `UART_RX_FIFO_EN` defined: the buffer is a `FIFO_DEPTH`-entry circular FIFO with `$clog2(FIFO_DEPTH)+1`-bit read and write pointers. Full = pointers equal apart from their MSB. Pointers wrap naturally.
- `UART_RX_FIFO_EN` undefined:
  - The buffer is a single holding register; `rd_valid` is its full flag.
  - A byte arriving while the register is full and not being popped is dropped and sets `overrun`. The old byte is kept.
  - `FIFO_DEPTH` is ignored.

## Test plan
- **Single byte:** reset, then send 8'hA5 at 115200 baud with `rd_en` held low → `rd_valid` rises at cycle 991 with `rd_data`=8'hA5. Then pulse `rd_en` → `rd_valid`=0 the next cycle.
- **Glitch rejection:** 20-cycle low glitch on idle `rx` → FSM returns to IDLE, `rd_valid` stays 0, no flags set.
- **Back-to-back and ordering:** 8 back-to-back bytes 8'h00..8'h07, no pops (FIFO build) → `rd_valid`=1, no overrun. A 9th byte 8'hFF → `overrun`=1. Draining yields 00..07 in order. Non-FIFO build: only 8'h00 is retained and `overrun`=1.
- **Framing error and break:** frame with the stop bit low, then `rx` held low for 3 frame times → exactly one `frame_err` assertion, no byte pushed. After `rx` returns high, 8'h3C is received correctly. `err_clr` → `frame_err`=0.
- **Full FIFO, simultaneous events:** FIFO full, `rd_en` asserted on the push cycle → no overrun and occupancy stays at `FIFO_DEPTH`. `err_clr` coinciding with an overrun condition → `overrun`=1.
- **Reset mid-frame:** `resetn` low during data bit 4, then a fresh 8'h5A frame → only 8'h5A is received and both flags are 0.
